// File: rtl/card_flip_ctrl_pkg.sv
// Shared definitions for the memory-board round controller: FSM state
// encodings, default symbol width, move-counter width and a saturating bump.
package card_flip_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FIRST   = 3'd0,
    ST_SECOND  = 3'd1,
    ST_COMPARE = 3'd2,
    ST_SHOW    = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  localparam int DEFAULT_SYM_W = 3;
  localparam int MOVES_W       = 10;

  // Move counter sticks at all-ones instead of wrapping.
  function automatic logic [MOVES_W-1:0] moves_sat_inc(input logic [MOVES_W-1:0] m);
    logic [MOVES_W-1:0] r;
    if (m == {MOVES_W{1'b1}}) begin
      r = m;
    end else begin
      r = m + {{(MOVES_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Registered rising-edge detector on vblnk; tick is a one-cycle pulse that
// marks the frame boundary.
module frame_tick_gen (
  input  logic pclk,
  input  logic rst_n,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_q;
  logic tick_q;

  // Delay line and registered edge pulse.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      tick_q  <= vblnk & ~vblnk_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/card_flip_ctrl.sv
// Game-round controller: selection FSM, pair compare, mismatch hold and the
// frame-committed face_up mask. Optional single-card timeout: CARD_CTRL_TIMEOUT_EN.
module card_flip_ctrl
  import card_flip_ctrl_pkg::*;
#(
  parameter int N_CARDS     = 16,
  parameter int IDX_W       = 4,
  parameter int SYM_W       = DEFAULT_SYM_W,
  parameter int SHOW_FRAMES = 60
`ifdef CARD_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_FRAMES = 300
`endif
) (
  input  logic                       pclk,
  input  logic                       rst_n,
  input  logic                       vblnk,
  input  logic                       new_game,
  input  logic                       sel_valid,
  input  logic [IDX_W-1:0]           sel_idx,
  input  logic [N_CARDS*SYM_W-1:0]   card_sym,
  output logic                       sel_ready,
  output logic [N_CARDS-1:0]         face_up,
  output logic [N_CARDS-1:0]         matched,
  output logic [IDX_W-1:0]           pair_count,
  output logic [MOVES_W-1:0]         moves,
  output logic                       game_over
);

  localparam int CNT_W = $clog2(SHOW_FRAMES + 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [IDX_W-1:0] PAIRS_ALL  = IDX_W'(N_CARDS / 2);
`ifdef CARD_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_FRAMES - 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  state_e             state_q;
  logic [IDX_W-1:0]   idx_a_q;
  logic [IDX_W-1:0]   idx_b_q;
  logic [N_CARDS-1:0] vis_q;
  logic [N_CARDS-1:0] matched_q;
  logic [N_CARDS-1:0] face_up_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [IDX_W-1:0]   pair_count_q;
  logic [MOVES_W-1:0] moves_q;
  logic               game_over_q;
  logic               sel_ready_q;

  logic               tick;
  logic [N_CARDS-1:0] vis_mask;
  logic [SYM_W-1:0]   sym_a;
  logic [SYM_W-1:0]   sym_b;
  logic               sel_in_range;
  logic               sel_card_vis;
  logic               sel_legal;

  frame_tick_gen u_tick (
    .pclk  (pclk),
    .rst_n (rst_n),
    .vblnk (vblnk),
    .tick  (tick)
  );

  assign vis_mask = vis_q | matched_q;
  assign sym_a    = card_sym[32'(idx_a_q) * SYM_W +: SYM_W];
  assign sym_b    = card_sym[32'(idx_b_q) * SYM_W +: SYM_W];

  // Out-of-range indices are treated as already visible so they never pass.
  always_comb begin
    sel_in_range = (32'(sel_idx) < 32'(N_CARDS));
    sel_card_vis = 1'b1;
    if (sel_in_range) begin
      sel_card_vis = vis_mask[sel_idx];
    end else begin
      sel_card_vis = 1'b1;
    end
    sel_legal = sel_valid & sel_ready_q & ~sel_card_vis;
  end

  // Round FSM with its datapath; new_game overrides every state.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FIRST;
      idx_a_q      <= '0;
      idx_b_q      <= '0;
      vis_q        <= '0;
      matched_q    <= '0;
      frame_cnt_q  <= '0;
      pair_count_q <= '0;
      moves_q      <= '0;
      game_over_q  <= 1'b0;
      sel_ready_q  <= 1'b1;
`ifdef CARD_CTRL_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else if (new_game) begin
      state_q      <= ST_FIRST;
      idx_a_q      <= '0;
      idx_b_q      <= '0;
      vis_q        <= '0;
      matched_q    <= '0;
      frame_cnt_q  <= '0;
      pair_count_q <= '0;
      moves_q      <= '0;
      game_over_q  <= 1'b0;
      sel_ready_q  <= 1'b1;
`ifdef CARD_CTRL_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_FIRST: begin
          if (sel_legal) begin
            vis_q[sel_idx] <= 1'b1;
            idx_a_q        <= sel_idx;
            state_q        <= ST_SECOND;
`ifdef CARD_CTRL_TIMEOUT_EN
            to_cnt_q       <= '0;
`endif
          end
        end
        ST_SECOND: begin
          if (sel_legal) begin
            vis_q[sel_idx] <= 1'b1;
            idx_b_q        <= sel_idx;
            state_q        <= ST_COMPARE;
            sel_ready_q    <= 1'b0;
          end
`ifdef CARD_CTRL_TIMEOUT_EN
          else if (tick) begin
            if (to_cnt_q == TO_LAST) begin
              vis_q[idx_a_q] <= 1'b0;
              state_q        <= ST_FIRST;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
`endif
        end
        ST_COMPARE: begin
          moves_q <= moves_sat_inc(moves_q);
          if (sym_a == sym_b) begin
            matched_q[idx_a_q] <= 1'b1;
            matched_q[idx_b_q] <= 1'b1;
            vis_q[idx_a_q]     <= 1'b0;
            vis_q[idx_b_q]     <= 1'b0;
            pair_count_q       <= pair_count_q + IDX_W'(1);
            if ((pair_count_q + IDX_W'(1)) == PAIRS_ALL) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
              sel_ready_q <= 1'b0;
            end else begin
              state_q     <= ST_FIRST;
              sel_ready_q <= 1'b1;
            end
          end else begin
            frame_cnt_q <= '0;
            state_q     <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (tick) begin
            if (frame_cnt_q == SHOW_LAST) begin
              vis_q[idx_a_q] <= 1'b0;
              vis_q[idx_b_q] <= 1'b0;
              state_q        <= ST_FIRST;
              sel_ready_q    <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OVER: begin
          sel_ready_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_FIRST;
          sel_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Visible mask only moves on a frame boundary so no card redraws mid-frame.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      face_up_q <= '0;
    end else if (tick) begin
      face_up_q <= vis_mask;
    end else begin
      face_up_q <= face_up_q;
    end
  end

  assign sel_ready  = sel_ready_q;
  assign face_up    = face_up_q;
  assign matched    = matched_q;
  assign pair_count = pair_count_q;
  assign moves      = moves_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_card_flip_ctrl.sv
// Directed bench for card_flip_ctrl with SHOW_FRAMES=4; the timeout scenario
// runs only when CARD_CTRL_TIMEOUT_EN is defined (TIMEOUT_FRAMES=3).
module tb_card_flip_ctrl;

  logic        pclk;
  logic        rst_n;
  logic        vblnk;
  logic        new_game;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic [47:0] card_sym;
  logic        sel_ready;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [3:0]  pair_count;
  logic [9:0]  moves;
  logic        game_over;

  int n_checks;
  int n_err;

  // Pair table: pair k uses symbol k.
  int pa [8] = '{0, 1, 2, 3, 4, 5, 6, 11};
  int pb [8] = '{8, 9, 10, 7, 12, 13, 14, 15};

  card_flip_ctrl #(
    .SHOW_FRAMES(4)
`ifdef CARD_CTRL_TIMEOUT_EN
    , .TIMEOUT_FRAMES(3)
`endif
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vblnk      (vblnk),
    .new_game   (new_game),
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .card_sym   (card_sym),
    .sel_ready  (sel_ready),
    .face_up    (face_up),
    .matched    (matched),
    .pair_count (pair_count),
    .moves      (moves),
    .game_over  (game_over)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic sel(input int idx);
    sel_valid = 1'b1;
    sel_idx   = 4'(idx);
    cyc(1);
    sel_valid = 1'b0;
  endtask

  task automatic frame();
    vblnk = 1'b1;
    cyc(2);
    vblnk = 1'b0;
    cyc(2);
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    vblnk     = 1'b0;
    new_game  = 1'b0;
    sel_valid = 1'b0;
    sel_idx   = 4'd0;
    card_sym  = 48'd0;
    for (int k = 0; k < 8; k++) begin
      card_sym[pa[k]*3 +: 3] = 3'(k);
      card_sym[pb[k]*3 +: 3] = 3'(k);
    end
    cyc(3);
    chk("rst_face_up", 32'(face_up), 32'h0);
    chk("rst_matched", 32'(matched), 32'h0);
    chk("rst_moves", 32'(moves), 32'h0);
    chk("rst_game_over", 32'(game_over), 32'h0);
    #3 rst_n = 1'b1;
    cyc(2);
    chk("rst_sel_ready", 32'(sel_ready), 32'h1);

    // Matching pair 3/7
    sel(3);
    sel(7);
    cyc(1);
    chk("t1_matched", 32'(matched), 32'h0088);
    chk("t1_pairs", 32'(pair_count), 32'h1);
    chk("t1_moves", 32'(moves), 32'h1);
    chk("t1_ready", 32'(sel_ready), 32'h1);
    chk("t1_face_pre_tick", 32'(face_up), 32'h0);
    frame();
    chk("t1_face_tick", 32'(face_up), 32'h0088);

    // Mismatch 2/5 held for 4 frames, with a dropped selection in SHOW
    sel(2);
    sel(5);
    cyc(1);
    chk("t2_ready_show", 32'(sel_ready), 32'h0);
    chk("t2_moves", 32'(moves), 32'h2);
    chk("t2_face_before", 32'(face_up), 32'h0088);
    frame();
    chk("t2_face_f1", 32'(face_up), 32'h00AC);
    sel(6);
    frame();
    chk("t2_face_f2", 32'(face_up), 32'h00AC);
    chk("t2_ready_f2", 32'(sel_ready), 32'h0);
    frame();
    chk("t2_face_f3", 32'(face_up), 32'h00AC);
    chk("t2_ready_f3", 32'(sel_ready), 32'h0);
    frame();
    chk("t2_face_f4", 32'(face_up), 32'h00AC);
    chk("t2_ready_after", 32'(sel_ready), 32'h1);
    frame();
    chk("t2_face_hidden", 32'(face_up), 32'h0088);
    chk("t2_moves_end", 32'(moves), 32'h2);

    // Illegal re-selection of a face-up and of a matched card
    sel(0);
    sel(0);
    sel(3);
    chk("t3_ready", 32'(sel_ready), 32'h1);
    chk("t3_moves", 32'(moves), 32'h2);
    chk("t3_matched", 32'(matched), 32'h0088);
    sel(8);
    cyc(1);
    chk("t3_matched_08", 32'(matched), 32'h0189);
    chk("t3_pairs", 32'(pair_count), 32'h2);
    chk("t3_moves_end", 32'(moves), 32'h3);

    // Finish the board
    for (int k = 0; k < 8; k++) begin
      if (pa[k] != 0 && pa[k] != 3) begin
        sel(pa[k]);
        sel(pb[k]);
        cyc(1);
      end
    end
    chk("t4_game_over", 32'(game_over), 32'h1);
    chk("t4_ready", 32'(sel_ready), 32'h0);
    chk("t4_pairs", 32'(pair_count), 32'h8);
    chk("t4_moves", 32'(moves), 32'h9);
    chk("t4_matched", 32'(matched), 32'hFFFF);
    frame();
    chk("t4_face_all", 32'(face_up), 32'hFFFF);
    new_game = 1'b1;
    cyc(1);
    new_game = 1'b0;
    chk("t4_ng_game_over", 32'(game_over), 32'h0);
    chk("t4_ng_matched", 32'(matched), 32'h0);
    chk("t4_ng_pairs", 32'(pair_count), 32'h0);
    chk("t4_ng_moves", 32'(moves), 32'h0);
    chk("t4_ng_ready", 32'(sel_ready), 32'h1);
    chk("t4_ng_face_held", 32'(face_up), 32'hFFFF);
    frame();
    chk("t4_ng_face_clear", 32'(face_up), 32'h0);

    // Async reset in the middle of SHOW
    sel(2);
    sel(5);
    cyc(1);
    frame();
    chk("t5_face_show", 32'(face_up), 32'h0024);
    chk("t5_moves_pre", 32'(moves), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_face", 32'(face_up), 32'h0);
    chk("t5_rst_moves", 32'(moves), 32'h0);
    #2 rst_n = 1'b1;
    cyc(1);
    sel(4);
    chk("t5_ready_second", 32'(sel_ready), 32'h1);
    frame();
    chk("t5_face_sel", 32'(face_up), 32'h0010);

`ifdef CARD_CTRL_TIMEOUT_EN
    // Lone card times out after 3 frames
    new_game = 1'b1;
    cyc(1);
    new_game = 1'b0;
    frame();
    sel(9);
    frame();
    chk("t6_face_f1", 32'(face_up), 32'h0200);
    frame();
    frame();
    chk("t6_face_f3", 32'(face_up), 32'h0200);
    frame();
    chk("t6_face_cleared", 32'(face_up), 32'h0);
    chk("t6_moves", 32'(moves), 32'h0);
    chk("t6_ready", 32'(sel_ready), 32'h1);
    sel(0);
    sel(8);
    cyc(1);
    chk("t6_first_again", 32'(matched), 32'h0101);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
